// File: rtl/flag_save_stack.sv
// flag_save_stack: LIFO of status flags, pushed on interrupt/CALL entry and
// popped on RTI/RET. saved_status feeds the status register restore path and
// restore_valid tells the control unit to issue the restore op that cycle.
// Optional build macro: FLAG_STACK_PARITY_EN adds a per-entry even-parity bit
// and drives parity_err alongside restore_valid.
module flag_save_stack #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              stall,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [FLAG_W-1:0] saved_status,
  output logic              restore_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              parity_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
`ifdef FLAG_STACK_PARITY_EN
  localparam int unsigned EntryW = FLAG_W + 1;
`else
  localparam int unsigned EntryW = FLAG_W;
`endif

  typedef enum logic [0:0] {StIdle, StRestore} state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   mem_q [DEPTH];
  logic [CNT_W-1:0]    sp_q, sp_d;
  logic [FLAG_W-1:0]   saved_status_q, saved_status_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                parity_q, parity_d;

  logic                do_push, do_pop, do_swap, pop_ok;
  logic                wr_en;
  logic [IdxW-1:0]     wr_idx, rd_idx;
  logic [EntryW-1:0]   wr_data, rd_data;

  assign count = sp_q;
  assign full  = (sp_q == CNT_W'(DEPTH));
  assign empty = (sp_q == '0);

  // Swap takes priority when both push and pop arrive on a non-empty stack;
  // push+pop on an empty stack degenerates to a plain push.
  assign do_swap = ~stall & push & pop & ~empty;
  assign do_pop  = ~stall & pop & ~push & ~empty;
  assign do_push = ~stall & push & ~do_swap & ~full;
  assign pop_ok  = do_pop | do_swap;

  assign rd_idx  = IdxW'(sp_q - CNT_W'(1));
  assign wr_idx  = do_swap ? rd_idx : IdxW'(sp_q);
  assign wr_en   = do_push | do_swap;
  assign rd_data = mem_q[rd_idx];
`ifdef FLAG_STACK_PARITY_EN
  assign wr_data = {^flags_in, flags_in};
`else
  assign wr_data = flags_in;
`endif

  // Next-state for pointer, restored flags, sticky errors and the FSM.
  always_comb begin
    sp_d           = sp_q;
    saved_status_d = saved_status_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
    parity_d       = parity_q;
    state_d        = state_q;

    if (do_push) sp_d = sp_q + CNT_W'(1);
    if (do_pop)  sp_d = sp_q - CNT_W'(1);

    // Read-before-write: a swap returns the old top entry.
    if (pop_ok) begin
      saved_status_d = rd_data[FLAG_W-1:0];
`ifdef FLAG_STACK_PARITY_EN
      parity_d = (^rd_data[FLAG_W-1:0]) != rd_data[FLAG_W];
`else
      parity_d = 1'b0;
`endif
    end

    if (~stall & push & ~pop & full) overflow_d = 1'b1;
    if (~stall & pop & empty)        underflow_d = 1'b1;

    // Stall holds RESTORE so the status register sees it once unstalled.
    if (!stall) state_d = pop_ok ? StRestore : StIdle;
  end

  assign restore_valid = (state_q == StRestore);
  assign saved_status  = saved_status_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;
  assign parity_err    = parity_q & restore_valid;

  // Control and status registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      sp_q           <= '0;
      saved_status_q <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      parity_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      saved_status_q <= saved_status_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      parity_q       <= parity_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_flag_save_stack.sv
// Directed testbench for flag_save_stack (DEPTH=4, FLAG_W=4).
module tb_flag_save_stack;

  logic       clk;
  logic       reset;
  logic       push, pop, stall;
  logic [3:0] flags_in;
  logic [3:0] saved_status;
  logic       restore_valid, full, empty;
  logic [2:0] count;
  logic       overflow_err, underflow_err, parity_err;

  int n_vec;
  int n_err;

  flag_save_stack #(
    .DEPTH (4),
    .FLAG_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .stall        (stall),
    .flags_in     (flags_in),
    .saved_status (saved_status),
    .restore_valid(restore_valid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic cyc(input logic p, input logic q, input logic s, input logic [3:0] f);
    push = p; pop = q; stall = s; flags_in = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    push = 1'b0; pop = 1'b0; stall = 1'b0; flags_in = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_saved", 8'(saved_status), 8'h0);
    check_val("rst_rv", 8'(restore_valid), 8'h0);
    check_val("rst_empty", 8'(empty), 8'h1);
    check_val("rst_full", 8'(full), 8'h0);
    check_val("rst_count", 8'(count), 8'h0);
    check_val("rst_ovf", 8'(overflow_err), 8'h0);
    check_val("rst_udf", 8'(underflow_err), 8'h0);
    check_val("rst_par", 8'(parity_err), 8'h0);
    reset = 1'b0;

    // Single push/pop round trip.
    cyc(1, 0, 0, 4'b1111);
    check_val("t1_count_push", 8'(count), 8'h1);
    check_val("t1_empty_push", 8'(empty), 8'h0);
    check_val("t1_rv_push", 8'(restore_valid), 8'h0);
    cyc(0, 1, 0, 4'b0000);
    check_val("t1_saved", 8'(saved_status), 8'hf);
    check_val("t1_rv", 8'(restore_valid), 8'h1);
    check_val("t1_count_pop", 8'(count), 8'h0);
    check_val("t1_empty_pop", 8'(empty), 8'h1);
    cyc(0, 0, 0, 4'b0000);
    check_val("t1_rv_drop", 8'(restore_valid), 8'h0);
    check_val("t1_saved_hold", 8'(saved_status), 8'hf);

    // Stalled push is ignored.
    cyc(1, 0, 1, 4'b0110);
    check_val("stall_push_count", 8'(count), 8'h0);

    // Fill, overflow, drain in LIFO order.
    cyc(1, 0, 0, 4'b0001);
    cyc(1, 0, 0, 4'b0010);
    cyc(1, 0, 0, 4'b0100);
    check_val("t2_full_early", 8'(full), 8'h0);
    cyc(1, 0, 0, 4'b1010);
    check_val("t2_full", 8'(full), 8'h1);
    check_val("t2_count4", 8'(count), 8'h4);
    check_val("t2_ovf_early", 8'(overflow_err), 8'h0);
    cyc(1, 0, 0, 4'b1111);
    check_val("t2_ovf", 8'(overflow_err), 8'h1);
    check_val("t2_count_ovf", 8'(count), 8'h4);
    cyc(0, 1, 0, 4'b0000);
    check_val("t2_pop1", 8'(saved_status), 8'ha);
    check_val("t2_rv1", 8'(restore_valid), 8'h1);
    cyc(0, 1, 0, 4'b0000);
    check_val("t2_pop2", 8'(saved_status), 8'h4);
    check_val("t2_rv2", 8'(restore_valid), 8'h1);
    cyc(0, 1, 0, 4'b0000);
    check_val("t2_pop3", 8'(saved_status), 8'h2);
    check_val("t2_rv3", 8'(restore_valid), 8'h1);
    cyc(0, 1, 0, 4'b0000);
    check_val("t2_pop4", 8'(saved_status), 8'h1);
    check_val("t2_rv4", 8'(restore_valid), 8'h1);
    check_val("t2_empty", 8'(empty), 8'h1);
    check_val("t2_udf_none", 8'(underflow_err), 8'h0);

    // Pop on empty: underflow, no restore, saved_status held.
    cyc(0, 1, 0, 4'b0000);
    check_val("t3_udf", 8'(underflow_err), 8'h1);
    check_val("t3_rv", 8'(restore_valid), 8'h0);
    check_val("t3_saved", 8'(saved_status), 8'h1);
    check_val("t3_count", 8'(count), 8'h0);

    // Pop followed by two stalled cycles holds the restore.
    cyc(1, 0, 0, 4'b1010);
    cyc(0, 1, 0, 4'b0000);
    check_val("t4_rv_c1", 8'(restore_valid), 8'h1);
    check_val("t4_saved_c1", 8'(saved_status), 8'ha);
    cyc(0, 0, 1, 4'b0000);
    check_val("t4_rv_c2", 8'(restore_valid), 8'h1);
    check_val("t4_saved_c2", 8'(saved_status), 8'ha);
    cyc(0, 0, 1, 4'b0000);
    check_val("t4_rv_c3", 8'(restore_valid), 8'h1);
    check_val("t4_saved_c3", 8'(saved_status), 8'ha);
    cyc(0, 0, 0, 4'b0000);
    check_val("t4_rv_drop", 8'(restore_valid), 8'h0);

    // Swap returns the old top and replaces it.
    cyc(1, 0, 0, 4'b0011);
    cyc(1, 1, 0, 4'b1100);
    check_val("t5_swap_saved", 8'(saved_status), 8'h3);
    check_val("t5_swap_rv", 8'(restore_valid), 8'h1);
    check_val("t5_swap_count", 8'(count), 8'h1);
    cyc(0, 1, 0, 4'b0000);
    check_val("t5_pop_saved", 8'(saved_status), 8'hc);
    check_val("t5_pop_count", 8'(count), 8'h0);
    check_val("t5_par", 8'(parity_err), 8'h0);

    // Asynchronous reset while in RESTORE.
    cyc(1, 0, 0, 4'b1010);
    cyc(0, 1, 0, 4'b0000);
    check_val("t6_rv_pre", 8'(restore_valid), 8'h1);
    #2 reset = 1'b1;
    #1;
    check_val("t6_rv", 8'(restore_valid), 8'h0);
    check_val("t6_saved", 8'(saved_status), 8'h0);
    check_val("t6_count", 8'(count), 8'h0);
    check_val("t6_ovf", 8'(overflow_err), 8'h0);
    check_val("t6_udf", 8'(underflow_err), 8'h0);
    #2 reset = 1'b0;
    cyc(0, 0, 0, 4'b0000);
    check_val("t6_empty_after", 8'(empty), 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flag_save_stack.md
Name: flag_save_stack

Overview:
- LIFO that saves the 4-bit status flags on interrupt/CALL entry and returns them on RTI/RET.
- It is the writer/source of the savedStatus bus that the status register loads during its restore operation (carry-op 2'b10).
- Sits between the status register and the control unit; restore_valid tells the control unit to issue the restore op that cycle.

Parameters:
DEPTH, 4, number of saved flag entries (power of two not required, >=2)
FLAG_W, 4, flag width; bit0 zero, bit1 negative, bit2 carry, bit3 reserved/dummy
CNT_W, $clog2(DEPTH+1), width of count output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
push  input  1  save flags_in (interrupt/CALL entry)
pop  input  1  restore request (RTI/RET)
stall  input  1  pipeline freeze; push/pop ignored, outputs held
flags_in  input  FLAG_W  current StatusFlags from status register
saved_status  output  FLAG_W  restored flags, registered; drives status register savedStatus
restore_valid  output  1  saved_status valid; control issues restore op while high
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CNT_W  number of stored entries
overflow_err  output  1  sticky; push attempted while full
underflow_err  output  1  sticky; pop attempted while empty
parity_err  output  1  see Optional Feature

Behaviour:
- Reset (async): sp=0, count=0, saved_status=0, restore_valid=0, empty=1, full=0, both sticky errors=0, parity_err=0, FSM=IDLE. Memory contents need not be cleared.
- All ops are sampled on the rising edge only when stall=0. stall=1 freezes sp, memory, saved_status and FSM.
- push only, not full: mem[sp]<=flags_in, sp<=sp+1. Visible through count/full on the next cycle.
- push only, full: no write; overflow_err<=1.
- pop only, not empty: sp<=sp-1, saved_status<=mem[sp-1], FSM->RESTORE. Latency 1: restore_valid is high the cycle after the pop edge.
- pop only, empty: sp unchanged, saved_status unchanged; underflow_err<=1; FSM->IDLE.
- push+pop together, not empty (swap):
  - saved_status<=mem[sp-1] and mem[sp-1]<=flags_in; sp unchanged.
  - FSM->RESTORE.
  - The read returns the old value (read-before-write).
- push+pop together, empty: treated as push only; underflow_err<=1.
- FSM IDLE:
  - restore_valid=0.
  - A valid pop moves to RESTORE.
- FSM RESTORE:
  - restore_valid=1.
  - If stall=1: stay, holding restore_valid and saved_status so the status register sees them once unstalled.
  - If stall=0 with no new valid pop: ->IDLE.
  - If stall=0 with a new valid pop: stay in RESTORE, load new data (back-to-back restores, one per cycle).
- Sticky errors clear only on reset.
- count==sp at all times; full/empty are combinational from count.
- saved_status is never X after reset.

Optional Feature:
- Macro FLAG_STACK_PARITY_EN.
- When defined:
  - Each entry stores FLAG_W+1 bits; the extra bit is the even parity of flags_in at write.
  - On each valid pop, parity is recomputed on the read data.
  - On mismatch, parity_err is high with restore_valid for the same cycle(s) and follows the same stall hold. It is not sticky.
- When not defined:
  - Entries are FLAG_W bits.
  - parity_err is tied to 0; the port is always present.

Test Plan:
- Reset, then push flags_in=4'b1111, then pop -> next cycle saved_status=4'b1111, restore_valid=1 for exactly 1 cycle, count 1->0, empty=1.
- Push 4'b0001, 4'b0010, 4'b0100, 4'b1010 (DEPTH=4), then 5th push 4'b1111:
  - full=1, overflow_err=1.
  - Four pops return 1010, 0100, 0010, 0001 in order, with restore_valid high 4 consecutive cycles.
- Pop with empty=1 -> underflow_err=1, restore_valid stays 0, saved_status unchanged.
- Push 4'b1010, then pop with stall=1 on the following two cycles -> restore_valid and saved_status=4'b1010 hold 3 cycles total, drop 1 cycle after stall=0.
- Push 4'b0011, then push+pop with flags_in=4'b1100 -> saved_status=4'b0011, count stays 1; next pop returns 4'b1100.
- Assert reset mid-RESTORE (after pop of 4'b1010) -> immediately restore_valid=0, saved_status=0, count=0, errors=0.
